// File: rtl/gate_sweep_checker.sv
// Self-test wrapper for a two-input gate block (AND/OR/NAND).
// Drives A/B through every input vector, holds each vector for SETTLE_CYCLES,
// then compares the three gate outputs against their truth tables in a single
// SAMPLE cycle. Failures accumulate per vector (err_mask) and per gate
// (fail_gate). A run is requested with start and reported via busy/done/pass.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int REPEAT        = 1,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       AND_In,
  input  logic       OR_In,
  input  logic       NAND_In,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] fail_gate
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       vec;
  logic [1:0]       vec_inc;
  logic [CNT_W-1:0] sweep;
  logic [CNT_W-1:0] settle;
  logic [2:0]       mismatch;

  // Per-gate mismatch against the truth table for the vector currently on A/B;
  // only consumed while in SAMPLE, so DRIVE-time glitches never reach the flags.
  always_comb begin
    vec_inc     = vec + 2'd1;
    mismatch[0] = (AND_In  != (A & B));
    mismatch[1] = (OR_In   != (A | B));
    mismatch[2] = (NAND_In != ~(A & B));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start is honoured only from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (settle == SETTLE_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (vec != 2'd3 || sweep != REPEAT_LAST) state_nxt = DRIVE;
        else                                     state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, registered gate inputs and sticky failure flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec       <= '0;
      sweep     <= '0;
      settle    <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      err_mask  <= '0;
      fail_gate <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= '0;
            sweep     <= '0;
            settle    <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            err_mask  <= '0;
            fail_gate <= '0;
          end
        end
        DRIVE: begin
          if (settle != SETTLE_LAST) settle <= settle + 1'b1;
        end
        SAMPLE: begin
          if (|mismatch) err_mask[vec] <= 1'b1;
          fail_gate <= fail_gate | mismatch;
          settle    <= '0;
          if (vec != 2'd3) begin
            vec <= vec_inc;
            A   <= vec_inc[1];
            B   <= vec_inc[0];
          end else begin
            // Next vector is 00 either for a new sweep or the idle value in DONE.
            A <= 1'b0;
            B <= 1'b0;
            if (sweep != REPEAT_LAST) begin
              sweep <= sweep + 1'b1;
              vec   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the state; pass is only meaningful with done.
  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
    pass = (state == DONE) && (fail_gate == 3'b000);
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (REPEAT=1 and REPEAT=3) driven by
// a behavioural gate block with selectable faults, checked cycle by cycle.
module tb_gate_sweep_checker;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  int          sel;
  int          mode;
  logic [11:0] flip;
  logic        glitch;

  logic       start1, a1, b1, and1, or1, nand1, busy1, done1, pass1;
  logic [3:0] em1;
  logic [2:0] fg1;
  logic       start3, a3, b3, and3, or3, nand3, busy3, done3, pass3;
  logic [3:0] em3;
  logic [2:0] fg3;

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_em;
  logic [2:0] o_fg;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Gate block model: bits {NAND, OR, AND}. Modes: 0 good, 1 AND stuck 0,
  // 2 OR/NAND swapped, 3 AND stuck 1, 5 random per-vector inversions.
  function automatic logic [2:0] gate_fn(input logic a, input logic b, input int m,
                                         input logic [11:0] fl, input logic gl);
    logic [2:0] g;
    int idx;
    g = {~(a & b), a | b, a & b};
    idx = 3 * int'({a, b});
    case (m)
      1: g[0] = 1'b0;
      2: g = {g[1], g[2], g[0]};
      3: g[0] = 1'b1;
      5: g = g ^ fl[idx +: 3];
      default: ;
    endcase
    if (gl) g[0] = ~g[0];
    return g;
  endfunction

  assign start1 = start && (sel == 0);
  assign start3 = start && (sel == 1);
  assign {nand1, or1, and1} = gate_fn(a1, b1, mode, flip, glitch);
  assign {nand3, or3, and3} = gate_fn(a3, b3, mode, flip, glitch);

  always_comb begin
    if (sel == 0) begin
      o_a = a1; o_b = b1; o_busy = busy1; o_done = done1; o_pass = pass1; o_em = em1; o_fg = fg1;
    end else begin
      o_a = a3; o_b = b3; o_busy = busy3; o_done = done3; o_pass = pass3; o_em = em3; o_fg = fg3;
    end
  end

  gate_sweep_checker #(.SETTLE_CYCLES(S), .REPEAT(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1),
    .AND_In(and1), .OR_In(or1), .NAND_In(nand1),
    .busy(busy1), .done(done1), .pass(pass1), .err_mask(em1), .fail_gate(fg1)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(S), .REPEAT(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .A(a3), .B(b3),
    .AND_In(and3), .OR_In(or3), .NAND_In(nand3),
    .busy(busy3), .done(done3), .pass(pass3), .err_mask(em3), .fail_gate(fg3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected flags from the truth table versus the faulty gate model, per vector.
  task automatic model(input int m, input logic [11:0] fl,
                       output logic [3:0] em, output logic [2:0] fg);
    logic [2:0] want, got;
    logic a, b;
    em = '0;
    fg = '0;
    for (int v = 0; v < 4; v++) begin
      a = v[1];
      b = v[0];
      want = {~(a & b), a | b, a & b};
      got  = gate_fn(a, b, m, fl, 1'b0);
      if (want != got) em[v] = 1'b1;
      fg = fg | (want ^ got);
    end
  endtask

  // One complete run: start on the next edge, check every cycle up to done.
  task automatic run(input string tag, input int m, input int rep, input bit hold, input bit noise);
    int n, v;
    logic [3:0] em;
    logic [2:0] fg;
    n = 4 * (S + 1) * rep;
    mode = m;
    model(m, flip, em, fg);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int t = 0; t < n; t++) begin
      v = (t / (S + 1)) % 4;
      check({tag, "_busy_ab"}, 16'({o_busy, o_done, o_a, o_b}), 16'({1'b1, 1'b0, v[1], v[0]}));
      if (t == 0) check({tag, "_cleared"}, 16'({o_em, o_fg}), 16'h0);
      if (noise) begin
        start  = (t == 3) || (t == 7);
        glitch = (t % (S + 1) == 0);
      end
      @(posedge clk); #1;
    end
    glitch = 1'b0;
    if (noise) start = 1'b0;
    check({tag, "_done"}, 16'({o_busy, o_done, o_a, o_b}), 16'({1'b0, 1'b1, 1'b0, 1'b0}));
    check({tag, "_flags"}, 16'({o_pass, o_em, o_fg}), 16'({(fg == 3'b000), em, fg}));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    sel    = 0;
    mode   = 0;
    flip   = '0;
    glitch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut1", 16'({busy1, done1, pass1, a1, b1, em1, fg1}), 16'h0);
    check("reset_dut3", 16'({busy3, done3, pass3, a3, b3, em3, fg3}), 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_no_start", 16'({busy1, done1}), 16'h0);

    run("clean", 0, 1, 1'b0, 1'b0);
    run("and_stuck0", 1, 1, 1'b0, 1'b0);
    run("or_nand_swap", 2, 1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      flip = 12'($urandom);
      run("random_fault", 5, 1, 1'($urandom_range(0, 1)), 1'b0);
    end
    start = 1'b0;
    flip  = '0;

    run("busy_start_glitch", 0, 1, 1'b0, 1'b1);

    // Reset after a vector-0 failure has been recorded, mid-run.
    mode  = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun_flag", 16'({o_busy, o_em}), 16'({1'b1, 4'b0001}));
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrun_reset", 16'({o_busy, o_done, o_pass, o_a, o_b, o_em, o_fg}), 16'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", 16'({o_busy, o_done, o_em, o_fg}), 16'h0);
    run("after_reset", 0, 1, 1'b0, 1'b0);

    sel = 1;
    run("rep3_clean", 0, 3, 1'b0, 1'b0);
    run("rep3_and_stuck1", 3, 3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
